// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares a single-port synchronous data memory between the
//             pipeline Mem stage (CPU port, fixed priority) and an external
//             host/debug port. A starvation counter forces one host slot
//             after MAX_WAIT contended cycles, stalling the CPU for exactly
//             one cycle.
//  Ports    : Clk/Rst            - clock, synchronous active-high reset
//             cpu_*              - CPU request (en/we/addr/wdata), rdata, stall
//             host_*             - host level request + fields, ack pulse,
//                                  registered read data
//             mem_*              - D_mem control/data pins and read data
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DSIZE    = 16,
    parameter int AW       = 10,
    parameter int MAX_WAIT = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    // CPU (Mem stage) port
    input  logic             cpu_en,
    input  logic             cpu_we,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [DSIZE-1:0] cpu_wdata,
    output logic [DSIZE-1:0] cpu_rdata,
    output logic             cpu_stall,
    // Host / debug port
    input  logic             host_req,
    input  logic             host_we,
    input  logic [AW-1:0]    host_addr,
    input  logic [DSIZE-1:0] host_wdata,
    output logic             host_ack,
    output logic [DSIZE-1:0] host_rdata,
    // D_mem pins
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DSIZE-1:0] mem_wdata,
    input  logic [DSIZE-1:0] mem_rdata
);

    // Counter must hold 0..MAX_WAIT; keep at least one bit when MAX_WAIT=0.
    localparam int c_WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [c_WW-1:0] c_MAX_CNT = c_WW'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_H_CAPT = 2'd1,
        S_H_ACK  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_WW-1:0]     r_wait_cnt;
    logic [c_WW-1:0]     w_wait_nxt;
    logic                r_host_wr;     // issued host access was a write
    logic [DSIZE-1:0]    r_host_rdata;
    logic                w_host_go;

    // Read data from the memory is never muxed: the host capture cycle can
    // never coincide with a CPU read return.
    assign cpu_rdata  = mem_rdata;
    assign host_rdata = r_host_rdata;

    always_comb begin
        w_next     = r_state;
        w_wait_nxt = r_wait_cnt;
        w_host_go  = host_req && (!cpu_en || (r_wait_cnt == c_MAX_CNT));
        mem_en     = cpu_en;
        mem_we     = cpu_we;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        cpu_stall  = 1'b0;
        host_ack   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_host_go) begin
                    mem_en     = 1'b1;
                    mem_we     = host_we;
                    mem_addr   = host_addr;
                    mem_wdata  = host_wdata;
                    cpu_stall  = cpu_en;
                    w_next     = S_H_CAPT;
                    w_wait_nxt = '0;
                end else if (!host_req) begin
                    w_wait_nxt = '0;
                end else if (r_wait_cnt != c_MAX_CNT) begin
                    // host_req && cpu_en here: a contended cycle
                    w_wait_nxt = r_wait_cnt + c_WW'(1);
                end
            end
            S_H_CAPT: begin
                w_next = S_H_ACK;
            end
            S_H_ACK: begin
                host_ack = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // No memory activity and no handshake while reset is applied.
        if (Rst) begin
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            cpu_stall = 1'b0;
            host_ack  = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_host_wr    <= 1'b0;
            r_host_rdata <= '0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_nxt;
            // Latch the access type at issue so capture does not depend on
            // the host keeping host_we stable.
            if ((r_state == S_IDLE) && w_host_go) begin
                r_host_wr <= host_we;
            end
            if ((r_state == S_H_CAPT) && !r_host_wr) begin
                r_host_rdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Self-checking bench for dmem_arbiter. A behavioural model of
//             the memory and the arbitration rules predicts stall/ack per
//             cycle and queues expected read data; a monitor pops the queues
//             whenever the DUT returns CPU or host read data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int DSIZE    = 16;
    localparam int AW       = 10;
    localparam int MAX_WAIT = 4;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic             cpu_en = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0]    cpu_addr = '0;
    logic [DSIZE-1:0] cpu_wdata = '0;
    logic [DSIZE-1:0] cpu_rdata;
    logic             cpu_stall;
    logic             host_req = 1'b0, host_we = 1'b0;
    logic [AW-1:0]    host_addr = '0;
    logic [DSIZE-1:0] host_wdata = '0;
    logic             host_ack;
    logic [DSIZE-1:0] host_rdata;
    logic             mem_en, mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DSIZE-1:0] mem_wdata;
    logic [DSIZE-1:0] mem_rdata = '0;

    always #5 Clk = ~Clk;

    dmem_arbiter #(.DSIZE(DSIZE), .AW(AW), .MAX_WAIT(MAX_WAIT)) u_dut (
        .Clk(Clk), .Rst(Rst),
        .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous single-port RAM standing in for D_mem.
    logic [DSIZE-1:0] ram [0:(1<<AW)-1];
    always @(posedge Clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // ---------------- reference model and scoreboard ----------------
    int               errors = 0;
    int               checks = 0;
    logic [DSIZE-1:0] model_mem [0:(1<<AW)-1];
    int               m_busy_age = 0;   // 0: no host access; 1: capture; 2: ack
    int               m_contended = 0;
    bit               m_host_wr = 1'b0;
    logic [DSIZE-1:0] m_pend = '0;
    logic [DSIZE-1:0] m_hrd = '0;
    bit               m_ack_now = 1'b0;
    logic [DSIZE-1:0] q_host [$];
    logic [DSIZE-1:0] q_cpu  [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // One clock cycle: drive inputs, check combinational outputs against the
    // model, then advance the model across the coming edge.
    task automatic step(input bit rst, input bit ce, input bit cw,
                        input logic [AW-1:0] ca, input logic [DSIZE-1:0] cd,
                        input bit hr, input bit hw,
                        input logic [AW-1:0] ha, input logic [DSIZE-1:0] hd);
        bit go;
        @(posedge Clk);
        #1;
        Rst = rst; cpu_en = ce; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
        #3;
        check("host_rdata_held", host_rdata, m_hrd);
        m_ack_now = 1'b0;
        if (rst) begin
            check("rst_mem_en_we", {mem_en, mem_we}, 2'b00);
            check("rst_cpu_stall", cpu_stall, 1'b0);
            check("rst_host_ack", host_ack, 1'b0);
            if (m_busy_age == 2) void'(q_host.pop_back());
            m_busy_age  = 0;
            m_contended = 0;
            m_hrd       = '0;
        end else begin
            go = (m_busy_age == 0) && hr && (!ce || m_contended == MAX_WAIT);
            check("cpu_stall", cpu_stall, go && ce);
            check("host_ack", host_ack, m_busy_age == 2);
            if (go) begin
                check("host_issue_pins", {mem_en, mem_we, mem_addr, mem_wdata},
                      {1'b1, hw, ha, hd});
                m_host_wr = hw;
                m_pend    = model_mem[ha];
                if (hw) model_mem[ha] = hd;
                m_busy_age  = 1;
                m_contended = 0;
            end else begin
                check("cpu_pins", {mem_en, mem_we, mem_addr, mem_wdata}, {ce, cw, ca, cd});
                if (ce) begin
                    if (cw) model_mem[ca] = cd;
                    else    q_cpu.push_back(model_mem[ca]);
                end
                if (m_busy_age == 0) begin
                    if (!hr)                           m_contended = 0;
                    else if (ce && m_contended < MAX_WAIT) m_contended++;
                end else if (m_busy_age == 1) begin
                    if (!m_host_wr) m_hrd = m_pend;
                    q_host.push_back(m_hrd);
                    m_busy_age = 2;
                end else begin
                    m_ack_now  = 1'b1;
                    m_busy_age = 0;
                end
            end
        end
    endtask

    // Hold a host request until the model says it is acknowledged.
    task automatic host_txn(input bit hw, input logic [AW-1:0] ha, input logic [DSIZE-1:0] hd,
                            input bit ce, input bit cw,
                            input logic [AW-1:0] ca, input logic [DSIZE-1:0] cd);
        int n;
        n = 0;
        do begin
            step(1'b0, ce, cw, ca, cd, 1'b1, hw, ha, hd);
            n++;
        end while (!m_ack_now && n < 20);
        if (!m_ack_now) fail("host_txn_timeout");
    endtask

    // Monitor: compares returned read data against queued expectations.
    bit prev_cpu_rd = 1'b0;
    always @(negedge Clk) begin
        if (prev_cpu_rd) begin
            if (q_cpu.size() == 0) fail("cpu_rdata_unexpected");
            else check("cpu_rdata", cpu_rdata, q_cpu.pop_front());
        end
        prev_cpu_rd = !Rst && cpu_en && !cpu_we && !cpu_stall;
        if (host_ack) begin
            if (q_host.size() == 0) fail("host_ack_unexpected");
            else check("host_ack_rdata", host_rdata, q_host.pop_front());
        end
    end

    initial begin
        bit               busy;
        bit               hw;
        logic [AW-1:0]    ha;
        logic [DSIZE-1:0] hd;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]       = '0;
            model_mem[i] = '0;
        end
        busy = 1'b0; hw = 1'b0; ha = '0; hd = '0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Uncontended host write then read of 0x005.
        host_txn(1, 10'h005, 16'hBEEF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        host_txn(0, 10'h005, 16'h0000, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Contended: CPU reads 0x010 every cycle, host read forced through.
        step(0, 1, 1, 10'h010, 16'h5A5A, 0, 0, 0, 0);
        host_txn(0, 10'h005, 16'h0000, 1, 0, 10'h010, 0);
        step(0, 1, 0, 10'h010, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // CPU write in the capture cycle, CPU read in the ack cycle.
        step(0, 0, 0, 0, 0, 1, 0, 10'h005, 0);
        step(0, 1, 1, 10'h3FF, 16'h1234, 1, 0, 10'h005, 0);
        step(0, 1, 0, 10'h3FF, 0, 1, 0, 10'h005, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset during the capture cycle of a host read.
        step(0, 0, 0, 0, 0, 1, 0, 10'h005, 0);
        step(1, 0, 0, 0, 0, 1, 0, 10'h005, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        host_txn(0, 10'h005, 16'h0000, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Back-to-back host reads of 0x001 and 0x002.
        step(0, 1, 1, 10'h001, 16'hA001, 0, 0, 0, 0);
        step(0, 1, 1, 10'h002, 16'hA002, 0, 0, 0, 0);
        host_txn(0, 10'h001, 16'h0000, 0, 0, 0, 0);
        host_txn(0, 10'h002, 16'h0000, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomised traffic over a small address window to create hits.
        for (int c = 0; c < 800; c++) begin
            bit rst, ce, cw;
            logic [AW-1:0]    ca;
            logic [DSIZE-1:0] cd;
            rst = ($urandom_range(63) == 0);
            if (!busy && $urandom_range(2) == 0) begin
                busy = 1'b1;
                hw   = 1'($urandom_range(1));
                ha   = AW'($urandom_range(15));
                hd   = DSIZE'($urandom);
            end
            ce = ($urandom_range(3) != 0);
            cw = 1'($urandom_range(1));
            ca = AW'($urandom_range(15));
            cd = DSIZE'($urandom);
            step(rst, ce, cw, ca, cd, busy, hw, ha, hd);
            if (m_ack_now) busy = 1'b0;
        end

        for (int c = 0; c < 4; c++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("host_queue_drained", q_host.size(), 0);
        check("cpu_queue_drained", q_cpu.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline Mem stage (CPU port) and an external host/debug port (loader, memory inspector).
- CPU has fixed priority.
- A starvation counter forces one host slot after MAX_WAIT contended cycles by stalling the CPU for exactly one cycle.
- Sits between the Mem stage and the D_mem instance and drives all D_mem control and data pins.

Parameters:
- DSIZE, 16, data word width.
- AW, 10, memory word-address width.
- MAX_WAIT, 4, contended cycles the host waits before a forced grant; 0 means the host always wins.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- cpu_en  in  1  CPU access request this cycle (from EX stage, unregistered).
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  AW  CPU word address.
- cpu_wdata  in  DSIZE  CPU write data.
- cpu_rdata  out  DSIZE  CPU read data; combinational passthrough of mem_rdata.
- cpu_stall  out  1  combinational; CPU access not performed this cycle, pipeline must hold.
- host_req  in  1  host request, level; held with host_we/addr/wdata stable until host_ack.
- host_we  in  1  host write enable.
- host_addr  in  AW  host word address.
- host_wdata  in  DSIZE  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DSIZE  registered host read data; held until the next capture.
- mem_en  out  1  to D_mem Enable.
- mem_we  out  1  to D_mem Write_Enab.
- mem_addr  out  AW  to D_mem Add_In.
- mem_wdata  out  DSIZE  to D_mem Data_in.
- mem_rdata  in  DSIZE  from D_mem Data_out; synchronous read, valid the cycle after issue.

Behaviour:
- Clock and reset: one clock, Clk. Reset Rst is synchronous and active-high.
- Reset values: state=IDLE, wait_cnt=0, host_rdata=0, host_ack=0, cpu_stall=0.
- While Rst=1: mem_en=0 and mem_we=0, so no writes occur during reset.
- States:
  - IDLE: CPU or host may issue.
  - H_CAPT: capture host read data.
  - H_ACK: acknowledge the host.
- Grant rule, evaluated in IDLE only; host_go = host_req && (!cpu_en || wait_cnt==MAX_WAIT).
- IDLE with host_go:
  - The host drives mem_en=1, mem_we=host_we, mem_addr=host_addr, mem_wdata=host_wdata.
  - cpu_stall=cpu_en.
  - Next state H_CAPT; wait_cnt<=0.
- IDLE without host_go:
  - The memory pins follow the CPU port (mem_en=cpu_en, etc.); cpu_stall=0.
  - If host_req && cpu_en, wait_cnt<=wait_cnt+1, saturating at MAX_WAIT.
  - If !host_req, wait_cnt<=0.
- H_CAPT:
  - The memory pins follow the CPU (no stall).
  - host_rdata<=mem_rdata when the access was a read; unchanged for a write.
  - Next state H_ACK.
- H_ACK:
  - host_ack=1; the memory pins follow the CPU; next state IDLE.
- host_ack is derived from the registered state: high for exactly one cycle per host access.
- Host latency: issue cycle T, capture at T+1, ack at T+2. A host write commits at the issue edge.
- Host handshake: the host deasserts host_req in the cycle after it sees host_ack. host_req still high in IDLE starts a new access (back-to-back allowed, minimum 3 cycles per access).
- cpu_rdata=mem_rdata always. Data for a CPU read issued at cycle T appears at T+1. The host's capture cycle never overlaps a CPU read return, because the CPU was stalled or idle in the issue cycle.
- Forced grant stalls the CPU for exactly one cycle. The held CPU request is served at T+1 (H_CAPT).
- wait_cnt width: clog2(MAX_WAIT+1), minimum 1.
- Rst asserted in H_CAPT or H_ACK: access abandoned, no host_ack, host_rdata cleared to 0. A write already issued remains committed.
- host_req dropped before ack: the access still completes and acks. The host must ignore the ack.

Test Plan:
- Reset, then host write addr 0x005 data 0xBEEF with cpu_en=0 -> mem_en=mem_we=1 in the issue cycle; host_ack pulses 2 cycles later; cpu_stall never rises.
- Host read addr 0x005 uncontended -> host_rdata=0xBEEF in the ack cycle, held after host_req drops.
- cpu_en=1 every cycle (reads of 0x010), host_req=1 with MAX_WAIT=4 -> host issues on the 5th contended cycle; cpu_stall=1 for that single cycle only; the CPU read of 0x010 is served the next cycle with correct cpu_rdata.
- CPU write 0x3FF=0x1234 in H_CAPT, then CPU read 0x3FF in H_ACK -> no stall; cpu_rdata=0x1234 the following cycle; host_rdata unaffected.
- Rst pulsed in the H_CAPT cycle of a host read -> no host_ack; host_rdata=0; state IDLE; a subsequent host read completes normally.
- Back-to-back host reads 0x001, 0x002 with host_req held -> acks exactly 3 cycles apart; host_rdata matches the memory contents each time.
